// File: rtl/execute_stage_pkg.sv
// Shared encodings for the decode and execute stages: ALU operation codes,
// execute FSM states and the branch-target helper.
package execute_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

  // Fields held across a multi-cycle multiply until its result is written.
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] store_data;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
  } ex_capture_t;

  function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                input logic [63:0] imm);
    return pc + (imm << 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier producing the low 64 bits of a*b in 64 cycles.
// done is asserted combinationally during the final iteration, with product valid.
module seq_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  logic [63:0] acc;
  logic [63:0] mcand;
  logic [63:0] mplier;
  logic [5:0]  cnt;

  // Low bits of a shift-add product are sign-agnostic, so negatives need no fix-up.
  assign product = acc + (mplier[0] ? mcand : 64'd0);
  assign done    = busy && (cnt == 6'd63);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain the shift and add in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 6'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle inline ALU plus a 64-cycle iterative multiply
// that stalls upstream while it runs.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] pc_in,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] imm,
  input  logic        ALUSrc,
  input  logic [3:0]  ALU_Ctrl,
  input  logic        Branch_in,
  input  logic        Mem_Read_in,
  input  logic        Mem_Write_in,
  input  logic        Mem_to_Reg_in,
  input  logic        regWrite_in,
  output logic [63:0] result,
  output logic        Zero,
  output logic [63:0] pcbranch,
  output logic [63:0] writeData,
  output logic        Branch,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Mem_to_Reg,
  output logic        regWrite,
  output logic        out_valid,
  output logic        stall
);

  ex_state_e   state;
  ex_capture_t cap;
  logic [63:0] op_b;
  logic [63:0] alu_result;
  logic        is_mul;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_product;

  assign op_b      = ALUSrc ? imm : rs2_data;
  assign is_mul    = (ALU_Ctrl == ALU_MUL);
  assign mul_start = (state == ST_IDLE) && !mul_busy && in_valid && is_mul;
  assign stall     = (state == ST_MUL);

  // NOTE: the default assignment before the case keeps this block latch-free
  // for undefined opcodes.
  always_comb begin
    alu_result = '0;
    case (ALU_Ctrl)
      ALU_AND: alu_result = rs1_data & op_b;
      ALU_OR:  alu_result = rs1_data | op_b;
      ALU_ADD: alu_result = rs1_data + op_b;
      ALU_SUB: alu_result = rs1_data - op_b;
      ALU_SLL: alu_result = rs1_data << op_b[5:0];
      ALU_SRL: alu_result = rs1_data >> op_b[5:0];
      ALU_XOR: alu_result = rs1_data ^ op_b;
      ALU_SLT: alu_result = {63'd0, $signed(rs1_data) < $signed(op_b)};
      default: alu_result = '0;
    endcase
  end

  seq_multiplier u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (rs1_data),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cap        <= '0;
      result     <= '0;
      Zero       <= 1'b0;
      pcbranch   <= '0;
      writeData  <= '0;
      Branch     <= 1'b0;
      Mem_Read   <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_to_Reg <= 1'b0;
      regWrite   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && !is_mul) begin
            result     <= alu_result;
            Zero       <= (alu_result == 64'd0);
            pcbranch   <= branch_target(pc_in, imm);
            writeData  <= rs2_data;
            Branch     <= Branch_in;
            Mem_Read   <= Mem_Read_in;
            Mem_Write  <= Mem_Write_in;
            Mem_to_Reg <= Mem_to_Reg_in;
            regWrite   <= regWrite_in;
            out_valid  <= 1'b1;
          end else begin
            // Bubble: side-effecting controls drop, data outputs hold.
            Branch    <= 1'b0;
            Mem_Read  <= 1'b0;
            Mem_Write <= 1'b0;
            regWrite  <= 1'b0;
            out_valid <= 1'b0;
            if (mul_start) begin
              cap   <= '{pc: pc_in, imm: imm, store_data: rs2_data,
                         branch: Branch_in, mem_read: Mem_Read_in,
                         mem_write: Mem_Write_in, mem_to_reg: Mem_to_Reg_in,
                         reg_write: regWrite_in};
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result     <= mul_product;
            Zero       <= (mul_product == 64'd0);
            pcbranch   <= branch_target(cap.pc, cap.imm);
            writeData  <= cap.store_data;
            Branch     <= cap.branch;
            Mem_Read   <= cap.mem_read;
            Mem_Write  <= cap.mem_write;
            Mem_to_Reg <= cap.mem_to_reg;
            regWrite   <= cap.reg_write;
            out_valid  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table-driven single-cycle ALU vectors
// plus directed bubble, multiply and reset-abort sequences.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] pc_in, rs1_data, rs2_data, imm;
  logic        ALUSrc;
  logic [3:0]  ALU_Ctrl;
  logic        Branch_in, Mem_Read_in, Mem_Write_in, Mem_to_Reg_in, regWrite_in;
  logic [63:0] result, pcbranch, writeData;
  logic        Zero, Branch, Mem_Read, Mem_Write, Mem_to_Reg, regWrite;
  logic        out_valid, stall;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_in(pc_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .ALUSrc(ALUSrc),
    .ALU_Ctrl(ALU_Ctrl), .Branch_in(Branch_in), .Mem_Read_in(Mem_Read_in),
    .Mem_Write_in(Mem_Write_in), .Mem_to_Reg_in(Mem_to_Reg_in),
    .regWrite_in(regWrite_in), .result(result), .Zero(Zero),
    .pcbranch(pcbranch), .writeData(writeData), .Branch(Branch),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_to_Reg(Mem_to_Reg),
    .regWrite(regWrite), .out_valid(out_valid), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl order: {Branch, Mem_Read, Mem_Write, Mem_to_Reg, regWrite}
  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] im;
    logic        src;
    logic [63:0] pc;
    logic [4:0]  ctl;
    logic [63:0] exp_result;
    logic        exp_zero;
    logic [63:0] exp_pcbranch;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] im, input logic src,
                       input logic [63:0] pc, input logic [4:0] ctl);
    in_valid = v; ALU_Ctrl = op; rs1_data = a; rs2_data = b; imm = im;
    ALUSrc = src; pc_in = pc;
    {Branch_in, Mem_Read_in, Mem_Write_in, Mem_to_Reg_in, regWrite_in} = ctl;
  endtask

  function automatic logic [4:0] ctl_out();
    return {Branch, Mem_Read, Mem_Write, Mem_to_Reg, regWrite};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " result"}, result, 64'd0);
    check({tag, " pcbranch"}, pcbranch, 64'd0);
    check({tag, " writeData"}, writeData, 64'd0);
    check({tag, " Zero/valid/stall"}, {61'd0, Zero, out_valid, stall}, 64'd0);
    check({tag, " controls"}, {59'd0, ctl_out()}, 64'd0);
  endtask

  // Runs a multiply from acceptance to the result cycle, counting stall cycles.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                         input logic src, input logic [63:0] pc, input logic [4:0] ctl,
                         input logic [63:0] exp_prod);
    int stall_cycles = 0;
    drive(1'b1, ALU_MUL, a, b, im, src, pc, ctl);
    tick();
    check("mul accept out_valid", {63'd0, out_valid}, 64'd0);
    // Unrelated traffic during the stall must be ignored.
    drive(1'b1, ALU_ADD, 64'd1, 64'd1, 64'd0, 1'b0, 64'h40, 5'b11111);
    for (int i = 0; i < 100 && stall; i++) begin
      stall_cycles++;
      if (out_valid !== 1'b0 || regWrite !== 1'b0)
        check("mul stall bubble", {62'd0, out_valid, regWrite}, 64'd0);
      tick();
    end
    drive(1'b0, ALU_ADD, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 5'b00000);
    check("mul stall cycles", 64'(stall_cycles), 64'd64);
    check("mul result", result, exp_prod);
    check("mul Zero", {63'd0, Zero}, {63'd0, exp_prod == 64'd0});
    check("mul out_valid", {63'd0, out_valid}, 64'd1);
    check("mul writeData", writeData, b);
    check("mul pcbranch", pcbranch, pc + (im << 1));
    check("mul controls", {59'd0, ctl_out()}, {59'd0, ctl});
    tick();
    check("mul valid one cycle", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD, 64'd5, 64'd7, 64'd4, 1'b0, 64'h200, 5'b00001, 64'd12, 1'b0, 64'h208};
    vecs[1]  = '{ALU_SUB, 64'd9, 64'd9, 64'd8, 1'b0, 64'h100, 5'b10000, 64'd0, 1'b1, 64'h110};
    vecs[2]  = '{ALU_SLT, '1, 64'd1, 64'd0, 1'b0, 64'd0, 5'b00001, 64'd1, 1'b0, 64'd0};
    vecs[3]  = '{ALU_SLL, 64'd1, 64'd0, 64'd65, 1'b1, 64'd0, 5'b00001, 64'd2, 1'b0, 64'h82};
    vecs[4]  = '{ALU_AND, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'h10, 5'b01011, 64'hF000, 1'b0, 64'h10};
    vecs[5]  = '{ALU_OR, 64'hF0F0, 64'h0F0F, 64'd0, 1'b0, 64'd0, 5'b00101, 64'hFFFF, 1'b0, 64'd0};
    vecs[6]  = '{ALU_XOR, 64'hFF, 64'h0F, 64'd0, 1'b0, 64'd0, 5'b00001, 64'hF0, 1'b0, 64'd0};
    vecs[7]  = '{ALU_SRL, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 1'b0, 64'd0, 5'b00001, 64'd1, 1'b0, 64'd0};
    vecs[8]  = '{ALU_SLT, 64'd1, '1, 64'd0, 1'b0, 64'd0, 5'b00001, 64'd0, 1'b1, 64'd0};
    vecs[9]  = '{ALU_ADD, '1, 64'd1, 64'd0, 1'b0, 64'd0, 5'b00001, 64'd0, 1'b1, 64'd0};
    vecs[10] = '{4'b1111, 64'd3, 64'd4, 64'd0, 1'b0, 64'd0, 5'b00011, 64'd0, 1'b1, 64'd0};
    vecs[11] = '{ALU_SUB, 64'd0, 64'd1, 64'd2, 1'b0, 64'h1000, 5'b00011, '1, 1'b0, 64'h1004};

    rst_n = 1'b0;
    drive(1'b0, ALU_AND, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 5'b00000);
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].src,
            vecs[i].pc, vecs[i].ctl);
      tick();
      check($sformatf("vec%0d result", i), result, vecs[i].exp_result);
      check($sformatf("vec%0d Zero", i), {63'd0, Zero}, {63'd0, vecs[i].exp_zero});
      check($sformatf("vec%0d pcbranch", i), pcbranch, vecs[i].exp_pcbranch);
      check($sformatf("vec%0d writeData", i), writeData, vecs[i].b);
      check($sformatf("vec%0d controls", i), {59'd0, ctl_out()}, {59'd0, vecs[i].ctl});
      check($sformatf("vec%0d valid/stall", i), {62'd0, out_valid, stall}, 64'd2);
    end

    // Bubble: controls drop, data outputs and Mem_to_Reg hold.
    drive(1'b0, ALU_ADD, 64'd8, 64'd8, 64'd0, 1'b0, 64'd0, 5'b00101);
    tick();
    check("bubble regWrite/Mem_Write/valid", {61'd0, regWrite, Mem_Write, out_valid}, 64'd0);
    check("bubble Branch/Mem_Read", {62'd0, Branch, Mem_Read}, 64'd0);
    check("bubble result hold", result, vecs[11].exp_result);
    check("bubble Mem_to_Reg hold", {63'd0, Mem_to_Reg}, 64'd1);

    run_mul(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 1'b0, 64'h300, 5'b00001,
            64'hFFFF_FFFF_FFFF_FFFA);
    run_mul(64'd7, 64'd99, 64'd6, 1'b1, 64'h20, 5'b00011, 64'd42);

    // Abort a multiply at iteration 30.
    drive(1'b1, ALU_MUL, 64'd5, 64'd5, 64'd0, 1'b0, 64'h80, 5'b00001);
    tick();
    drive(1'b0, ALU_ADD, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 5'b00000);
    for (int i = 0; i < 30; i++) tick();
    check("pre-abort stall", {63'd0, stall}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-mul reset");
    #1;
    rst_n = 1'b1;
    drive(1'b1, ALU_ADD, 64'd1, 64'd1, 64'd0, 1'b0, 64'd0, 5'b00001);
    tick();
    check("post-reset add result", result, 64'd2);
    check("post-reset valid/stall", {62'd0, out_valid, stall}, 64'd2);
    drive(1'b0, ALU_ADD, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 5'b00000);
    tick();
    check("post-reset no stale product", {62'd0, out_valid, stall}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
